sa2x2_ctrl: RTL and testbench

Job sequencer for the 2x2 output-stationary systolic array (four PEs: `clk`, `rst`, `a`, `b`, accumulated `c`). It accepts one pair of 2x2 operand matrices A and B over a valid/ready handshake and clears the PE accumulators. It then drives the skewed operand schedule into the array's `inputt`/`weight` ports, waits out the PE latency, and presents C = A x B on a valid/ready result port. It sits between the job source (DMA or host shim) and the array instance.

---
 rtl/sa2x2_pkg.sv | 18 +
 rtl/sa2x2_feed.sv | 32 +++
 rtl/sa2x2_ctrl.sv | 150 +++++++++++++++
 tb/tb_sa2x2_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sa2x2_pkg.sv
// Shared types and constants for the 2x2 systolic-array job sequencer.
package sa2x2_pkg;

  localparam int SA_N       = 2;
  localparam int FEED_STEPS = 2 * SA_N;
  localparam int CNT_W      = $clog2(FEED_STEPS);
  localparam int SA_DW_DEF  = 16;
  localparam int SA_AW_DEF  = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } sa2x2_state_t;

endpackage

// File: rtl/sa2x2_feed.sv
// Combinational operand skew: PE(i,j) sees A[i][k] / B[k][j] with k = t-i-j,
// or zero when k falls outside the reduction range or feeding is disabled.
module sa2x2_feed
  import sa2x2_pkg::*;
#(
  parameter int DW = SA_DW_DEF
) (
  input  logic [0:SA_N-1][0:SA_N-1][DW-1:0] a_i,
  input  logic [0:SA_N-1][0:SA_N-1][DW-1:0] b_i,
  input  logic [CNT_W-1:0]                  step_i,
  input  logic                              feed_en_i,
  output logic [0:SA_N-1][0:SA_N-1][DW-1:0] inputt_o,
  output logic [0:SA_N-1][0:SA_N-1][DW-1:0] weight_o
);

  localparam int KW = $clog2(SA_N);

  for (genvar gi = 0; gi < SA_N; gi++) begin : g_row
    for (genvar gj = 0; gj < SA_N; gj++) begin : g_col
      // Signed so that early steps (t < i+j) go negative instead of wrapping.
      logic signed [CNT_W+1:0] k;
      logic                    hit;

      assign k   = $signed({2'b00, step_i}) - (CNT_W+2)'(gi + gj);
      assign hit = feed_en_i && (k >= 0) && (k < (CNT_W+2)'(SA_N));

      assign inputt_o[gi][gj] = hit ? a_i[gi][k[KW-1:0]] : '0;
      assign weight_o[gi][gj] = hit ? b_i[k[KW-1:0]][gj] : '0;
    end
  end

endmodule

// File: rtl/sa2x2_ctrl.sv
// Job sequencer for the 2x2 output-stationary array: accept A/B, clear, feed skewed
// operands, drain PE latency, present C. Optional counters under SA2X2_CTRL_PERF_EN.
module sa2x2_ctrl
  import sa2x2_pkg::*;
#(
  parameter int DW     = SA_DW_DEF,
  parameter int AW     = SA_AW_DEF,
  parameter int PE_LAT = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [0:SA_N-1][0:SA_N-1][DW-1:0] a_mat,
  input  logic [0:SA_N-1][0:SA_N-1][DW-1:0] b_mat,
  output logic                              arr_rst,
  output logic [0:SA_N-1][0:SA_N-1][DW-1:0] arr_inputt,
  output logic [0:SA_N-1][0:SA_N-1][DW-1:0] arr_weight,
  input  logic [0:SA_N-1][0:SA_N-1][AW-1:0] arr_outputt,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [0:SA_N-1][0:SA_N-1][AW-1:0] c_mat
`ifdef SA2X2_CTRL_PERF_EN
  ,
  output logic [15:0]                       job_cnt,
  output logic [31:0]                       stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_FEED  = CNT_W'(FEED_STEPS - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(PE_LAT - 1);

  sa2x2_state_t state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic [0:SA_N-1][0:SA_N-1][AW-1:0] c_q, c_d;
  logic [0:SA_N-1][0:SA_N-1][DW-1:0] a_q, a_d, b_q, b_d;
  logic feed_en;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;
    a_d         = a_q;
    b_d         = b_q;
    feed_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a_mat;
          b_d     = b_mat;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        step_d  = '0;
        state_d = FEED;
      end
      FEED: begin
        feed_en = 1'b1;
        if (step_q == LAST_FEED) begin
          step_d  = '0;
          state_d = DRAIN;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DRAIN: begin
        if (step_q == LAST_DRAIN) begin
          c_d         = arr_outputt;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        // in_ready is low here, so a new job can never overlap the result handshake.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

  sa2x2_feed #(
    .DW(DW)
  ) u_feed (
    .a_i      (a_q),
    .b_i      (b_q),
    .step_i   (step_q),
    .feed_en_i(feed_en),
    .inputt_o (arr_inputt),
    .weight_o (arr_weight)
  );

  assign arr_rst   = rst & (state_q != CLEAR);
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign c_mat     = c_q;

`ifdef SA2X2_CTRL_PERF_EN
  logic [15:0] job_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      job_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (state_q == DONE) begin
      if (out_ready) begin
        job_cnt_q <= job_cnt_q + 16'd1;
      end else if (stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign job_cnt   = job_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sa2x2_ctrl.sv
// Self-checking bench for sa2x2_ctrl with a behavioural 2x2 PE array and a
// cycle-level reference model derived from the job timing rules.
module tb_sa2x2_ctrl;

  localparam int DW     = 16;
  localparam int AW     = 32;
  localparam int PE_LAT = 1;

  typedef logic [0:1][0:1][DW-1:0] opm_t;
  typedef logic [0:1][0:1][AW-1:0] resm_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  in_valid = 1'b0;
  logic  out_ready = 1'b0;
  opm_t  a_mat = '0;
  opm_t  b_mat = '0;
  logic  in_ready, out_valid, arr_rst;
  opm_t  arr_inputt, arr_weight;
  resm_t arr_outputt, c_mat, pe_c;
`ifdef SA2X2_CTRL_PERF_EN
  logic [15:0] job_cnt;
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  sa2x2_ctrl #(.DW(DW), .AW(AW), .PE_LAT(PE_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_mat      (a_mat),
    .b_mat      (b_mat),
    .arr_rst    (arr_rst),
    .arr_inputt (arr_inputt),
    .arr_weight (arr_weight),
    .arr_outputt(arr_outputt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .c_mat      (c_mat)
`ifdef SA2X2_CTRL_PERF_EN
    ,
    .job_cnt    (job_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // Stand-in array: one-cycle PE latency, signed multiply-accumulate, cleared by arr_rst.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (!arr_rst) pe_c[i][j] <= '0;
        else pe_c[i][j] <= pe_c[i][j] + 32'(int'($signed(arr_inputt[i][j])) * int'($signed(arr_weight[i][j])));
  end
  assign arr_outputt = pe_c;

  // Reference model state: age = cycles since the accept edge (0 when not busy).
  int    age = 0;
  bit    valid_exp = 0, rdy_exp = 0, acc_evt = 0;
  resm_t c_exp = '0, pending = '0;
  opm_t  m_a = '0, m_b = '0;
  int    job_exp = 0, stall_exp = 0;
  int    n_checks = 0, n_pass = 0, rstlow_cnt = 0, job_no = 0;
  opm_t  cap_a[4], cap_b[4], lit_a[4], lit_b[4];

  function automatic opm_t mk(input int a00, a01, a10, a11);
    return {16'(a00), 16'(a01), 16'(a10), 16'(a11)};
  endfunction

  function automatic resm_t mkr(input int c00, c01, c10, c11);
    return {32'(c00), 32'(c01), 32'(c10), 32'(c11)};
  endfunction

  function automatic resm_t matmul(input opm_t a, input opm_t b);
    resm_t r;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        int s = 0;
        for (int k = 0; k < 2; k++) s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
        r[i][j] = 32'(s);
      end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic model_step();
    acc_evt = 0;
    if (!rst) begin
      age = 0; valid_exp = 0; rdy_exp = 0; c_exp = '0; job_exp = 0; stall_exp = 0;
    end else begin
      if (valid_exp) begin
        if (out_ready) begin valid_exp = 0; job_exp = (job_exp + 1) % 65536; end
        else stall_exp++;
      end else if (age > 0) begin
        if (age == 5 + PE_LAT) begin valid_exp = 1; c_exp = pending; age = 0; end
        else age++;
      end else if (rdy_exp && in_valid) begin
        m_a = a_mat; m_b = b_mat; pending = matmul(a_mat, b_mat); age = 1; acc_evt = 1;
      end
      rdy_exp = (age == 0) && !valid_exp;
    end
  endtask

  task automatic compare();
    opm_t ei = '0, ew = '0;
    if (age >= 2 && age <= 5)
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          int k = age - 2 - i - j;
          if (k >= 0 && k <= 1) begin ei[i][j] = m_a[i][k]; ew[i][j] = m_b[k][j]; end
        end
    chk("in_ready", in_ready, rdy_exp);
    chk("out_valid", out_valid, valid_exp);
    chk("arr_rst", arr_rst, rst && (age != 1));
    chk("c_mat", c_mat, c_exp);
    chk("arr_inputt", arr_inputt, ei);
    chk("arr_weight", arr_weight, ew);
`ifdef SA2X2_CTRL_PERF_EN
    chk("job_cnt", job_cnt, 16'(job_exp));
    chk("stall_cnt", stall_cnt, 32'(stall_exp));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
    if (arr_rst === 1'b0) rstlow_cnt++;
    if (age >= 2 && age <= 5) begin cap_a[age-2] = arr_inputt; cap_b[age-2] = arr_weight; end
  endtask

  task automatic run_job(input opm_t a, input opm_t b, input int stall, input bit pulse,
                         output int lat, output resm_t res);
    int n = 0;
    a_mat = a; b_mat = b; in_valid = 1'b1; out_ready = 1'b0;
    do begin tick(); n++; end while (!acc_evt && n < 20);
    chk("accept", acc_evt, 1'b1);
    in_valid = 1'b0;
    a_mat = mk($urandom, $urandom, $urandom, $urandom);
    lat = 0;
    do begin tick(); lat++; end while (out_valid !== 1'b1 && lat < 40);
    chk("valid_seen", out_valid, 1'b1);
    res = c_mat;
    for (int s = 0; s < stall; s++) begin
      in_valid = pulse & s[0];
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    job_no++;
    $display("job %0d: latency=%0d stall=%0d c=%h", job_no, lat, stall, res);
  endtask

  initial begin
    int    lat, n;
    resm_t res;

    lit_a[0] = mk(1, 0, 0, 0); lit_b[0] = mk(5, 0, 0, 0);
    lit_a[1] = mk(2, 1, 3, 0); lit_b[1] = mk(7, 6, 5, 0);
    lit_a[2] = mk(0, 2, 4, 3); lit_b[2] = mk(0, 8, 7, 6);
    lit_a[3] = mk(0, 0, 0, 4); lit_b[3] = mk(0, 0, 0, 8);

    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_arr_rst", arr_rst, 1'b0);
    chk("rst_c_mat", c_mat, '0);
    chk("rst_operands", {arr_inputt, arr_weight}, '0);
    rst = 1'b1;
    tick();
    chk("release_in_ready", in_ready, 1'b1);

    // Basic job with skew and latency pinned to hand-computed values.
    rstlow_cnt = 0;
    run_job(mk(1, 2, 3, 4), mk(5, 6, 7, 8), 0, 0, lat, res);
    chk("basic_latency", lat, 6);
    chk("basic_c", res, mkr(19, 22, 43, 50));
    chk("basic_arr_rst_low_cycles", rstlow_cnt, 1);
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("skew_a_t%0d", t), cap_a[t], lit_a[t]);
      chk($sformatf("skew_b_t%0d", t), cap_b[t], lit_b[t]);
    end

    // Back-pressure with ignored in_valid pulses.
    run_job(mk(2, 0, 1, 3), mk(1, 4, 5, 2), 10, 1, lat, res);
    chk("bp_c", res, mkr(2, 8, 16, 10));
    chk("bp_in_ready_after", in_ready, 1'b1);
    chk("bp_c_held", c_mat, mkr(2, 8, 16, 10));

    // Back-to-back jobs.
    run_job(mk(1, 0, 0, 1), mk(9, -3, 2, 7), 0, 0, lat, res);
    chk("b2b_first", res, mkr(9, -3, 2, 7));
    run_job(mk(-1, 0, 0, -1), mk(1, 1, 1, 1), 0, 0, lat, res);
    chk("b2b_second", res, mkr(-1, -1, -1, -1));

    // Reset asserted during FEED t=2.
    a_mat = mk(7, 7, 7, 7); b_mat = mk(7, 7, 7, 7); in_valid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!acc_evt && n < 20);
    in_valid = 1'b0;
    n = 0;
    while (age != 4 && n < 20) begin tick(); n++; end
    chk("rmf_reached_t2", age, 4);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rmf_out_valid", out_valid, 1'b0);
    chk("rmf_in_ready", in_ready, 1'b0);
    chk("rmf_operands", {arr_inputt, arr_weight}, '0);
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (out_valid === 1'b1) n++; end
    chk("rmf_no_result", n, 0);
    run_job(mk(3, 1, 2, 2), mk(1, 2, 3, 4), 0, 0, lat, res);
    chk("rmf_next_job", res, mkr(6, 10, 8, 12));

    // Randomised traffic, back-pressure and occasional resets against the model.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) != 0);
      a_mat     = mk($urandom, $urandom, $urandom, $urandom);
      b_mat     = mk($urandom, $urandom, $urandom, $urandom);
      tick();
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;

`ifdef SA2X2_CTRL_PERF_EN
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    run_job(mk(1, 2, 3, 4), mk(5, 6, 7, 8), 0, 0, lat, res);
    run_job(mk(1, 0, 0, 1), mk(9, -3, 2, 7), 5, 0, lat, res);
    run_job(mk(-1, 0, 0, -1), mk(1, 1, 1, 1), 0, 0, lat, res);
    chk("perf_job_cnt", job_cnt, 16'd3);
    chk("perf_stall_cnt", stall_cnt, 32'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
